// File: rtl/gbuff_reader_if.sv
// rtl/gbuff_reader_if.sv - valid/ready word stream leaving the global buffer reader
interface gbuff_reader_if #(
  parameter int WORD_SIZE = 128
);
  logic                 out_valid;
  logic                 out_ready;
  logic [WORD_SIZE-1:0] out_data;
  logic                 out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/gbuff_reader.sv
// rtl/gbuff_reader.sv - global buffer read streamer with credit-controlled output FIFO
module gbuff_reader #(
  parameter int WORD_SIZE  = 128,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      len,
  output logic                 busy,
  output logic                 done,
  output logic                 sram_wen,
  output logic [ADDR_W-1:0]    sram_addr,
  input  logic [WORD_SIZE-1:0] sram_do,
  gbuff_reader_if.master       stream
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t              state, next_state;
  logic [ADDR_W-1:0]   cur_addr;
  logic [ADDR_W-1:0]   addr_hold;
  logic [ADDR_W:0]     remaining;
  logic                issue;
  logic                inflight;
  logic                inflight_last;

  logic [WORD_SIZE-1:0] mem [FIFO_DEPTH];
  logic                 last_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 push, pop, non_empty;

  assign sram_wen  = 1'b0;
  assign sram_addr = issue ? cur_addr : addr_hold;

  assign non_empty        = (count != '0);
  assign push             = inflight;
  assign pop              = non_empty & stream.out_ready;
  assign stream.out_valid = non_empty;
  assign stream.out_data  = non_empty ? mem[rd_ptr] : '0;
  assign stream.out_last  = non_empty & last_mem[rd_ptr];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next state, read issue credit check and status outputs
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) next_state = (len == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        busy  = 1'b1;
        // a read in flight already owns a FIFO slot, so it counts against the credit
        issue = (remaining != '0) && ((count + CW'(inflight)) < DEPTH_C);
        if (issue && remaining == (ADDR_W+1)'(1)) next_state = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && stream.out_last) next_state = DONE;
      end
      DONE: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Command capture, address walk and one-cycle read-latency tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_addr      <= '0;
      addr_hold     <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == (ADDR_W+1)'(1));
      if (state == IDLE && start) begin
        cur_addr  <= base_addr;
        remaining <= len;
      end else if (issue) begin
        cur_addr  <= cur_addr + ADDR_W'(1);
        remaining <= remaining - (ADDR_W+1)'(1);
        addr_hold <= cur_addr;
      end
    end
  end

  // FIFO storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr]      <= sram_do;
      last_mem[wr_ptr] <= inflight_last;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_gbuff_reader.sv
// tb/tb_gbuff_reader.sv - self-checking bench for gbuff_reader
module tb_gbuff_reader;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [9:0]   base_addr;
  logic [10:0]  len;
  logic         busy, done, sram_wen;
  logic [9:0]   sram_addr;
  logic [127:0] sram_do;

  gbuff_reader_if #(.WORD_SIZE(128)) s ();

  gbuff_reader #(.WORD_SIZE(128), .ADDR_W(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_do(sram_do), .stream(s.master)
  );

  always #5 clk = ~clk;

  logic [127:0] mem [1024];
  always @(posedge clk) sram_do <= mem[sram_addr];

  int vectors = 0;
  int miscompares = 0;

  int cyc, done_cnt, done_cyc, first_valid, wen_bad;
  logic [127:0] got_data[$];
  logic         got_last[$];
  logic [9:0]   addr_at  [64];
  logic         valid_at [64];
  logic         busy_at  [64];
  logic [127:0] data_at  [64];

  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    int          exp_first;
    int          exp_done;
    logic        exp_busy1;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input longint got, input longint exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic rdy);
    @(posedge clk); #1;
    start = st;
    s.out_ready = rdy;
    @(negedge clk);
    if (cyc < 64) begin
      addr_at[cyc]  = sram_addr;
      valid_at[cyc] = s.out_valid;
      busy_at[cyc]  = busy;
      data_at[cyc]  = s.out_data;
    end
    if (sram_wen !== 1'b0) wen_bad++;
    if (s.out_valid && rdy) begin
      got_data.push_back(s.out_data);
      got_last.push_back(s.out_last);
    end
    if (s.out_valid && first_valid < 0) first_valid = cyc;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
  endtask

  // mode 0: ready always 1; mode 1: random ready; mode 2: ready low for cycles 0..9
  task automatic run_cmd(input logic [9:0] b, input logic [10:0] l, input int mode,
                         input int restart_cyc, input int budget);
    logic rdy;
    int   tail;
    got_data.delete();
    got_last.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; cyc = 0; tail = -1;
    base_addr = b;
    len = l;
    for (int c = 0; c < budget; c++) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = 1'($urandom_range(0, 1));
        default: rdy = (c >= 10);
      endcase
      step(c == 0 || c == restart_cyc, rdy);
      if (done_cnt != 0 && tail < 0) tail = 4;
      if (tail > 0) tail--;
      if (tail == 0) break;
    end
    start = 1'b0;
    chk("cmd_completed", longint'(done_cnt != 0), 1);
  endtask

  task automatic check_stream(input string name, input logic [9:0] b, input int l);
    int bad;
    logic [9:0] a;
    bad = 0;
    chk({name, "_word_count"}, got_data.size(), l);
    for (int i = 0; i < got_data.size() && i < l; i++) begin
      a = b + 10'(i);
      if (got_data[i] !== mem[a] || got_last[i] !== (i == l - 1)) bad++;
    end
    chk({name, "_bad_words"}, bad, 0);
    chk({name, "_done_count"}, done_cnt, 1);
  endtask

  initial begin
    int bad;
    logic [9:0] rb;
    int rl;

    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 4; i++) mem[16 + i] = 128'(8'hA0 + i);

    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; s.out_ready = 1'b0;
    wen_bad = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_status", {busy, done, sram_wen, s.out_valid, s.out_last}, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_out_data_zero", longint'(s.out_data == '0), 1);
    @(posedge clk); #1;
    reset = 1'b0;

    tbl[0] = '{10'h010, 11'd4,  3,  7, 1'b1};
    tbl[1] = '{10'h3FE, 11'd4,  3,  7, 1'b1};
    tbl[2] = '{10'h000, 11'd1,  3,  4, 1'b1};
    tbl[3] = '{10'h3FF, 11'd1,  3,  4, 1'b1};
    tbl[4] = '{10'h100, 11'd0, -1,  1, 1'b0};
    tbl[5] = '{10'h200, 11'd7,  3, 10, 1'b1};
    tbl[6] = '{10'h3F8, 11'd16, 3, 19, 1'b1};
    for (int i = 0; i < 7; i++) begin
      run_cmd(tbl[i].base, tbl[i].len, 0, -1, 200);
      chk($sformatf("tbl%0d_first_valid", i), first_valid, tbl[i].exp_first);
      chk($sformatf("tbl%0d_done_cycle", i), done_cyc, tbl[i].exp_done);
      chk($sformatf("tbl%0d_busy_c1", i), busy_at[1], tbl[i].exp_busy1);
      check_stream($sformatf("tbl%0d", i), tbl[i].base, int'(tbl[i].len));
    end

    // basic stream: explicit words and last flag position in cycles 3..6
    run_cmd(10'h010, 11'd4, 0, -1, 100);
    bad = 0;
    for (int c = 3; c <= 6; c++)
      if (!valid_at[c] || data_at[c] !== 128'(8'hA0 + c - 3)) bad++;
    chk("basic_words_c3_c6", bad, 0);
    chk("basic_last_on_a3", {got_last[0], got_last[1], got_last[2], got_last[3]}, 4'b0001);

    // wrap-around address sequence
    run_cmd(10'h3FE, 11'd4, 0, -1, 100);
    chk("wrap_addr_c1", addr_at[1], 10'h3FE);
    chk("wrap_addr_c2", addr_at[2], 10'h3FF);
    chk("wrap_addr_c3", addr_at[3], 10'h000);
    chk("wrap_addr_c4", addr_at[4], 10'h001);
    check_stream("wrap", 10'h3FE, 4);

    // back-pressure: ready low for cycles 0..9
    run_cmd(10'h040, 11'd10, 2, -1, 200);
    chk("bp_addr_c9_four_reads", addr_at[9], 10'h043);
    chk("bp_valid_c9", valid_at[9], 1);
    chk("bp_head_c3", longint'(data_at[3] === mem[10'h040]), 1);
    chk("bp_head_stable_c9", longint'(data_at[9] === mem[10'h040]), 1);
    chk("bp_done_cycle", done_cyc, 20);
    check_stream("bp", 10'h040, 10);

    // start during a running command is ignored
    run_cmd(10'h080, 11'd8, 0, 2, 100);
    chk("restart_done_cycle", done_cyc, 11);
    check_stream("restart", 10'h080, 8);

    // reset in cycle 5 of a 16-word command
    got_data.delete(); got_last.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; cyc = 0;
    base_addr = 10'h150; len = 11'd16;
    for (int c = 0; c < 5; c++) step(c == 0, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", s.out_valid, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_cmd(10'h2A0, 11'd5, 0, -1, 100);
    chk("post_rst_done_cycle", done_cyc, 8);
    check_stream("post_rst", 10'h2A0, 5);

    // random short commands under random back-pressure
    for (int k = 0; k < 6; k++) begin
      rb = 10'($urandom);
      rl = $urandom_range(1, 40);
      run_cmd(rb, 11'(rl), 1, -1, 2000);
      check_stream($sformatf("rand%0d", k), rb, rl);
    end

    // full buffer under random back-pressure
    rb = 10'($urandom);
    run_cmd(rb, 11'd1024, 1, -1, 20000);
    check_stream("full1024", rb, 1024);

    chk("sram_wen_never_set", wen_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
